// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// pll_lock_sequencer
// PLL RESETB/LOCK supervisor on the reference clock; optional lock-loss
// auto-recovery enabled by defining PLL_SEQ_AUTO_RECOVER_EN.
// Revision: 1.0
// ============================================================================
module pll_lock_sequencer #(
   parameter int PLL_RESET_CYCLES = 16,
   parameter int LOCK_TIMEOUT     = 16000,
   parameter int STABLE_CYCLES    = 256,
   parameter int MAX_RETRIES      = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pll_locked,
   output logic       pll_resetb,
   output logic       sys_reset,
   output logic       ready,
   output logic       lock_lost,
   output logic       fail,
   output logic [3:0] retry_count
);

   localparam int C_MAX_A = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
   localparam int C_MAX_P = (C_MAX_A > STABLE_CYCLES) ? C_MAX_A : STABLE_CYCLES;
   localparam int C_CNT_W = (C_MAX_P > 1) ? $clog2(C_MAX_P) : 1;

   localparam logic [C_CNT_W-1:0] C_RST_LAST = C_CNT_W'(PLL_RESET_CYCLES - 1);
   localparam logic [C_CNT_W-1:0] C_TMO_LAST = C_CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [C_CNT_W-1:0] C_STB_LAST = C_CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]         C_RETRY_MAX = 4'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t             r_state;
   logic [C_CNT_W-1:0] r_cnt;
   logic               r_lk_meta;
   logic               r_lk_s;
   logic               r_pll_resetb;
   logic               r_sys_reset;
   logic               r_ready;
   logic               r_lock_lost;
   logic               r_fail;
   logic [3:0]         r_retry_count;
   logic [3:0]         w_retry_next;

   assign w_retry_next = r_retry_count + 4'd1;

   // pll_resetb follows the next state; sys_reset/ready/fail follow the
   // current state one cycle late, so release lands STABLE_CYCLES+3 edges
   // after lock is first sampled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_PLL_RST;
         r_cnt         <= '0;
         r_lk_meta     <= 1'b0;
         r_lk_s        <= 1'b0;
         r_pll_resetb  <= 1'b0;
         r_sys_reset   <= 1'b1;
         r_ready       <= 1'b0;
         r_lock_lost   <= 1'b0;
         r_fail        <= 1'b0;
         r_retry_count <= 4'd0;
      end else begin
         r_lk_meta   <= pll_locked;
         r_lk_s      <= r_lk_meta;
         r_lock_lost <= 1'b0;
         r_sys_reset <= (r_state != S_RUN);
         r_ready     <= (r_state == S_RUN);
         r_fail      <= (r_state == S_FAIL);

         case (r_state)
            S_PLL_RST: begin
               if (r_cnt == C_RST_LAST) begin
                  r_state      <= S_WAIT_LOCK;
                  r_cnt        <= '0;
                  r_pll_resetb <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + C_CNT_W'(1);
               end
            end
            S_WAIT_LOCK: begin
               if (r_lk_s) begin
                  r_state <= S_STABLE;
                  r_cnt   <= '0;
               end else if (r_cnt == C_TMO_LAST) begin
                  r_cnt         <= '0;
                  r_retry_count <= w_retry_next;
                  r_pll_resetb  <= 1'b0;
                  r_state       <= (w_retry_next == C_RETRY_MAX) ? S_FAIL : S_PLL_RST;
               end else begin
                  r_cnt <= r_cnt + C_CNT_W'(1);
               end
            end
            S_STABLE: begin
               if (!r_lk_s) begin
                  r_state <= S_WAIT_LOCK;
                  r_cnt   <= '0;
               end else if (r_cnt == C_STB_LAST) begin
                  r_state       <= S_RUN;
                  r_cnt         <= '0;
                  r_retry_count <= 4'd0;
               end else begin
                  r_cnt <= r_cnt + C_CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!r_lk_s) begin
                  r_lock_lost  <= 1'b1;
                  r_cnt        <= '0;
                  r_pll_resetb <= 1'b0;
`ifdef PLL_SEQ_AUTO_RECOVER_EN
                  r_state       <= S_PLL_RST;
                  r_retry_count <= 4'd0;
`else
                  r_state <= S_FAIL;
`endif
               end
            end
            S_FAIL: begin
               r_pll_resetb <= 1'b0;
            end
            default: begin
               r_state      <= S_PLL_RST;
               r_cnt        <= '0;
               r_pll_resetb <= 1'b0;
            end
         endcase
      end
   end

   assign pll_resetb  = r_pll_resetb;
   assign sys_reset   = r_sys_reset;
   assign ready       = r_ready;
   assign lock_lost   = r_lock_lost;
   assign fail        = r_fail;
   assign retry_count = r_retry_count;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pll_lock_sequencer
// Self-checking bench: phase-level reference model plus directed timing pins.
// Revision: 1.0
// ============================================================================
module tb_pll_lock_sequencer;

   localparam int RC = 4;
   localparam int TO = 20;
   localparam int SC = 8;
   localparam int MR = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       pll_locked = 1'b0;
   logic       pll_resetb;
   logic       sys_reset;
   logic       ready;
   logic       lock_lost;
   logic       fail;
   logic [3:0] retry_count;

   int total = 0;
   int bad   = 0;

   pll_lock_sequencer #(
      .PLL_RESET_CYCLES(RC),
      .LOCK_TIMEOUT    (TO),
      .STABLE_CYCLES   (SC),
      .MAX_RETRIES     (MR)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .pll_locked (pll_locked),
      .pll_resetb (pll_resetb),
      .sys_reset  (sys_reset),
      .ready      (ready),
      .lock_lost  (lock_lost),
      .fail       (fail),
      .retry_count(retry_count)
   );

   always #5 clock = ~clock;

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phases with countdown budgets; lock seen two edges late.
   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_STB  = 2;
   localparam int P_RUN  = 3;
   localparam int P_FAIL = 4;

   int         m_phase;
   int         m_left;
   int         m_retry;
   logic       lk_hist[$];
   logic       exp_pll_resetb = 1'b0;
   logic       exp_sys_reset  = 1'b1;
   logic       exp_ready      = 1'b0;
   logic       exp_lock_lost  = 1'b0;
   logic       exp_fail       = 1'b0;
   logic [3:0] exp_retry      = 4'd0;

   always @(posedge clock or posedge reset) begin : model
      int   prev;
      logic lk;
      if (reset) begin
         m_phase = P_RST;
         m_left  = RC;
         m_retry = 0;
         lk_hist.delete();
         exp_pll_resetb = 1'b0;
         exp_sys_reset  = 1'b1;
         exp_ready      = 1'b0;
         exp_lock_lost  = 1'b0;
         exp_fail       = 1'b0;
         exp_retry      = 4'd0;
      end else begin
         lk = (lk_hist.size() >= 2) ? lk_hist[lk_hist.size()-2] : 1'b0;
         lk_hist.push_back(pll_locked);
         if (lk_hist.size() > 3) void'(lk_hist.pop_front());
         prev = m_phase;
         exp_lock_lost = 1'b0;
         case (m_phase)
            P_RST: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = P_WAIT;
                  m_left  = TO;
               end
            end
            P_WAIT: begin
               if (lk) begin
                  m_phase = P_STB;
                  m_left  = SC;
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_retry++;
                     if (m_retry == MR) m_phase = P_FAIL;
                     else begin
                        m_phase = P_RST;
                        m_left  = RC;
                     end
                  end
               end
            end
            P_STB: begin
               if (!lk) begin
                  m_phase = P_WAIT;
                  m_left  = TO;
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase = P_RUN;
                     m_retry = 0;
                  end
               end
            end
            P_RUN: begin
               if (!lk) begin
                  exp_lock_lost = 1'b1;
`ifdef PLL_SEQ_AUTO_RECOVER_EN
                  m_phase = P_RST;
                  m_left  = RC;
                  m_retry = 0;
`else
                  m_phase = P_FAIL;
`endif
               end
            end
            default: ;
         endcase
         exp_pll_resetb = (m_phase == P_WAIT) || (m_phase == P_STB) || (m_phase == P_RUN);
         exp_sys_reset  = (prev != P_RUN);
         exp_ready      = (prev == P_RUN);
         exp_fail       = (prev == P_FAIL);
         exp_retry      = 4'(m_retry);
      end
   end

   always @(negedge clock) begin
      chk1("pll_resetb", pll_resetb, exp_pll_resetb);
      chk1("sys_reset", sys_reset, exp_sys_reset);
      chk1("ready", ready, exp_ready);
      chk1("lock_lost", lock_lost, exp_lock_lost);
      chk1("fail", fail, exp_fail);
      chk4("retry_count", retry_count, exp_retry);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Asserts reset mid-cycle, checks outputs before any clock edge, releases on a negedge.
   task automatic apply_reset();
      #2 reset = 1'b1;
      #1;
      chk1("async_rst_pll_resetb", pll_resetb, 1'b0);
      chk1("async_rst_sys_reset", sys_reset, 1'b1);
      chk1("async_rst_ready", ready, 1'b0);
      chk1("async_rst_lock_lost", lock_lost, 1'b0);
      chk1("async_rst_fail", fail, 1'b0);
      chk4("async_rst_retry", retry_count, 4'd0);
      @(negedge clock);
      @(negedge clock);
      pll_locked = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      apply_reset();

      // Lock from cycle 10, then lose it in RUN.
      tick(3);
      chk1("resetb_low_e3", pll_resetb, 1'b0);
      tick(1);
      chk1("resetb_rise_e4", pll_resetb, 1'b1);
      tick(5);
      pll_locked = 1'b1;
      tick(11);
      chk1("sysrst_held_lock_plus10", sys_reset, 1'b1);
      tick(1);
      chk1("sysrst_fall_lock_plus11", sys_reset, 1'b0);
      chk1("ready_after_release", ready, 1'b1);
      chk4("retry_zero_run", retry_count, 4'd0);
      tick(3);
      pll_locked = 1'b0;
      tick(2);
      chk1("lock_lost_not_yet", lock_lost, 1'b0);
      tick(1);
      chk1("lock_lost_pulse", lock_lost, 1'b1);
      chk1("ready_during_pulse", ready, 1'b1);
      tick(1);
      chk1("lock_lost_one_cycle", lock_lost, 1'b0);
      chk1("sysrst_after_loss", sys_reset, 1'b1);
      chk1("ready_after_loss", ready, 1'b0);
`ifdef PLL_SEQ_AUTO_RECOVER_EN
      chk1("no_fail_recover", fail, 1'b0);
      chk1("recover_resetb_low", pll_resetb, 1'b0);
      tick(2);
      chk1("recover_resetb_low_4th", pll_resetb, 1'b0);
      tick(1);
      chk1("recover_resetb_rise", pll_resetb, 1'b1);
`else
      chk1("fail_after_loss", fail, 1'b1);
      chk1("fail_resetb_low", pll_resetb, 1'b0);
`endif

      // No lock: two timeouts then FAIL.
      apply_reset();
      tick(23);
      chk4("retry_before_tmo1", retry_count, 4'd0);
      tick(1);
      chk4("retry_tmo1", retry_count, 4'd1);
      tick(23);
      chk4("retry_before_tmo2", retry_count, 4'd1);
      tick(1);
      chk4("retry_tmo2", retry_count, 4'd2);
      chk1("resetb_low_tmo2", pll_resetb, 1'b0);
      chk1("fail_not_yet", fail, 1'b0);
      tick(1);
      chk1("fail_latched", fail, 1'b1);
      chk1("sysrst_in_fail", sys_reset, 1'b1);
      tick(20);
      chk1("fail_held", fail, 1'b1);
      chk1("resetb_held_fail", pll_resetb, 1'b0);

      // Lock at cycle 30 after one timeout.
      apply_reset();
      tick(29);
      pll_locked = 1'b1;
      tick(5);
      chk4("retry_in_stable", retry_count, 4'd1);
      tick(6);
      chk4("retry_cleared_run", retry_count, 4'd0);
      chk1("sysrst_held_c40", sys_reset, 1'b1);
      tick(1);
      chk1("sysrst_fall_c41", sys_reset, 1'b0);
      chk1("ready_c41", ready, 1'b1);

      // Reset while in RUN, then one-cycle glitch during STABLE.
      apply_reset();
      tick(9);
      pll_locked = 1'b1;
      tick(6);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(11);
      chk1("glitch_sysrst_held", sys_reset, 1'b1);
      tick(1);
      chk1("glitch_sysrst_fall", sys_reset, 1'b0);
      chk4("glitch_no_retry", retry_count, 4'd0);

      // Reset while in WAIT_LOCK, then clean restart.
      apply_reset();
      tick(8);
      chk1("wait_resetb_high", pll_resetb, 1'b1);
      apply_reset();
      tick(3);
      chk1("restart_resetb_low", pll_resetb, 1'b0);
      tick(1);
      chk1("restart_resetb_rise", pll_resetb, 1'b1);

      for (int run = 0; run < 8; run++) begin
         int budget;
         int seg;
         int maxseg;
         apply_reset();
         maxseg = (run % 2 == 0) ? 40 : 6;
         budget = int'($urandom_range(150, 450));
         while (budget > 0) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            seg = int'($urandom_range(1, maxseg));
            tick(seg);
            budget -= seg;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
